// File: rtl/mc_controller_if.sv
// Control bus between the multi-cycle controller (master) and its datapath (slave):
// instruction fields and the ALU flag come in, all datapath enables and selects go out.
interface mc_controller_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               PCWrite;
    logic [1:0]         PCSrc;
    logic               IRWrite;
    logic [1:0]         RegDst;
    logic               ALUSrc;
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic [1:0]         MemtoReg;
    logic               ExtOp;
    logic [ALUOP_W-1:0] ALUOp;
    logic               done;
    logic               illegal;
    logic [3:0]         state;

    modport master (
        input  op, funct, zero,
        output PCWrite, PCSrc, IRWrite, RegDst, ALUSrc, RegWrite, MemRead,
               MemWrite, MemtoReg, ExtOp, ALUOp, done, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  PCWrite, PCSrc, IRWrite, RegDst, ALUSrc, RegWrite, MemRead,
               MemWrite, MemtoReg, ExtOp, ALUOp, done, illegal, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset controller: Moore FSM with a per-state wait counter that
// stretches the memory states by MEM_LAT cycles.
module mc_controller #(
    parameter int MEM_LAT = 0,
    parameter int ALUOP_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1, S_EXE_R  = 4'd2,  S_EXE_I = 4'd3,
        S_MEM_ADR = 4'd4,  S_MEM_RD = 4'd5, S_MEM_WR = 4'd6,  S_WB_R  = 4'd7,
        S_WB_I    = 4'd8,  S_WB_MEM = 4'd9, S_BRANCH = 4'd10, S_JUMP  = 4'd11
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000, OP_J   = 6'b000010, OP_JAL = 6'b000011,
                           OP_BEQ = 6'b000100, OP_ORI = 6'b001101, OP_LUI = 6'b001111,
                           OP_LW  = 6'b100011, OP_SW  = 6'b101011;
    localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_JR = 6'b001000;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last;

    logic       pc_write, ir_write, alu_src, reg_write, mem_read, mem_write, ext_op;
    logic       done_c, illegal_c;
    logic [1:0] pc_src, reg_dst, memto_reg;
    logic [2:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        ir_write  = 1'b0;
        reg_dst   = 2'b00;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        memto_reg = 2'b00;
        ext_op    = 1'b0;
        alu_op    = 3'b000;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        last      = (cnt_q == 4'(MEM_LAT));
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (last) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.op)
                    OP_R: begin
                        if (bus.funct == FN_ADDU || bus.funct == FN_SUBU) state_d = S_EXE_R;
                        else if (bus.funct == FN_JR)                      state_d = S_JUMP;
                        else begin
                            illegal_c = 1'b1;
                            done_c    = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW:   state_d = S_MEM_ADR;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_ORI, OP_LUI: state_d = S_EXE_I;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        done_c    = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXE_R: state_d = S_WB_R;
            S_WB_R: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXE_I: begin
                if (bus.op == OP_LUI) begin
                    alu_op = 3'b011;
                end else begin
                    alu_src = 1'b1;
                    ext_op  = 1'b1;
                    alu_op  = 3'b111;
                end
                state_d = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                memto_reg = (bus.op == OP_LUI) ? 2'b01 : 2'b00;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADR: begin
                alu_src = 1'b1;
                alu_op  = 3'b001;
                state_d = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (last) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                if (last) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_MEM: begin
                memto_reg = 2'b10;
                reg_write = 1'b1;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = 3'b010;
                pc_src   = 2'b01;
                pc_write = bus.zero;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = (bus.op == OP_R) ? 2'b11 : 2'b10;
                if (bus.op == OP_JAL) begin
                    reg_dst   = 2'b10;
                    memto_reg = 2'b11;
                    reg_write = 1'b1;
                end
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Counter restarts on any state change and saturates rather than wrapping.
        if (state_d != state_q)  cnt_d = 4'd0;
        else if (cnt_q != 4'hF)  cnt_d = cnt_q + 4'd1;
        else                     cnt_d = cnt_q;
    end

    // Reset gates every output combinationally so nothing leaks while reset is held.
    assign bus.PCWrite  = pc_write  & ~reset;
    assign bus.PCSrc    = reset ? 2'b00 : pc_src;
    assign bus.IRWrite  = ir_write  & ~reset;
    assign bus.RegDst   = reset ? 2'b00 : reg_dst;
    assign bus.ALUSrc   = alu_src   & ~reset;
    assign bus.RegWrite = reg_write & ~reset;
    assign bus.MemRead  = mem_read  & ~reset;
    assign bus.MemWrite = mem_write & ~reset;
    assign bus.MemtoReg = reset ? 2'b00 : memto_reg;
    assign bus.ExtOp    = ext_op    & ~reset;
    assign bus.ALUOp    = reset ? '0 : ALUOP_W'(alu_op);
    assign bus.done     = done_c    & ~reset;
    assign bus.illegal  = illegal_c & ~reset;
    assign bus.state    = reset ? 4'd0 : state_q;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench: three controllers (MEM_LAT 0, 2, 3) driven with hand-derived
// per-cycle output vectors for each instruction class, plus reset cases.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [5:0] op_r = 6'd0, funct_r = 6'd0;
    logic       zero_r = 1'b0;
    int         sel = 0;
    int         checks = 0, errors = 0;
    logic [21:0] vec [3];
    logic [21:0] exp_q [$];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
            mc_controller_if #(.ALUOP_W(3)) u_if ();
            mc_controller #(.MEM_LAT(LAT), .ALUOP_W(3)) u_dut (
                .clk   (clk),
                .reset (rst[gi]),
                .bus   (u_if.master)
            );
            assign u_if.op    = op_r;
            assign u_if.funct = funct_r;
            assign u_if.zero  = zero_r;
            assign vec[gi] = {u_if.state, u_if.PCWrite, u_if.PCSrc, u_if.IRWrite, u_if.RegDst,
                              u_if.ALUSrc, u_if.RegWrite, u_if.MemRead, u_if.MemWrite,
                              u_if.MemtoReg, u_if.ExtOp, u_if.ALUOp, u_if.done, u_if.illegal};
        end
    endgenerate

    // Field order: state, PCWrite, PCSrc, IRWrite, RegDst, ALUSrc, RegWrite, MemRead,
    // MemWrite, MemtoReg, ExtOp, ALUOp, done, illegal.
    function automatic logic [21:0] pk(input logic [3:0] st, input logic pcw, input logic [1:0] pcs,
                                       input logic irw, input logic [1:0] rd, input logic als,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic [1:0] m2r, input logic ext, input logic [2:0] alu,
                                       input logic dn, input logic il);
        return {st, pcw, pcs, irw, rd, als, rw, mr, mw, m2r, ext, alu, dn, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    task automatic add_fetch(input int lat);
        for (int i = 0; i < lat; i++) exp_q.push_back(pk(0,0,0,0,0,0,0,1,0,0,0,0,0,0));
        exp_q.push_back(pk(0,1,0,1,0,0,0,1,0,0,0,0,0,0));
    endtask

    task automatic add_wait(input logic [21:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Drives the instruction at a falling edge and compares one vector per cycle.
    task automatic go(input string tag, input int s, input logic [5:0] o, input logic [5:0] f,
                      input logic z);
        int e0;
        e0 = errors;
        sel = s; op_r = o; funct_r = f; zero_r = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            chk($sformatf("%s_c%0d", tag, i + 1), {10'd0, vec[sel]}, {10'd0, exp_q[i]});
            @(negedge clk);
        end
        $display("instr %-8s lat_dut=%0d op=%b funct=%b zero=%b cycles=%0d errs=%0d",
                 tag, s, o, f, z, exp_q.size(), errors - e0);
        exp_q.delete();
    endtask

    localparam logic [21:0] V_DEC = 22'd0 | (22'd1 << 18);

    initial begin
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("rst_dut%0d", k), {10'd0, vec[k]}, 32'd0);
        @(negedge clk);

        // MEM_LAT = 0 controller
        rst[0] = 1'b0;
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
        exp_q.push_back(pk(7,0,0,0,1,0,1,0,0,0,0,0,1,0));
        go("addu", 0, 6'b000000, 6'b100001, 0);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
        exp_q.push_back(pk(7,0,0,0,1,0,1,0,0,0,0,0,1,0));
        go("subu", 0, 6'b000000, 6'b100011, 0);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(11,1,3,0,0,0,0,0,0,0,0,0,1,0));
        go("jr", 0, 6'b000000, 6'b001000, 0);
        add_fetch(0); exp_q.push_back(pk(1,0,0,0,0,0,0,0,0,0,0,0,1,1));
        go("badfn", 0, 6'b000000, 6'b000111, 0);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(3,0,0,0,0,1,0,0,0,0,1,7,0,0));
        exp_q.push_back(pk(8,0,0,0,0,0,1,0,0,0,0,0,1,0));
        go("ori", 0, 6'b001101, 6'b000000, 0);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(3,0,0,0,0,0,0,0,0,0,0,3,0,0));
        exp_q.push_back(pk(8,0,0,0,0,0,1,0,0,1,0,0,1,0));
        go("lui", 0, 6'b001111, 6'b000000, 0);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(10,0,1,0,0,0,0,0,0,0,0,2,1,0));
        go("beq_z0", 0, 6'b000100, 6'b000000, 0);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(10,1,1,0,0,0,0,0,0,0,0,2,1,0));
        go("beq_z1", 0, 6'b000100, 6'b000000, 1);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(11,1,2,0,0,0,0,0,0,0,0,0,1,0));
        go("j", 0, 6'b000010, 6'b000000, 0);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(11,1,2,0,2,0,1,0,0,3,0,0,1,0));
        go("jal", 0, 6'b000011, 6'b000000, 0);
        add_fetch(0); exp_q.push_back(pk(1,0,0,0,0,0,0,0,0,0,0,0,1,1));
        go("illop", 0, 6'b111111, 6'b000000, 0);
        add_fetch(0); exp_q.push_back(V_DEC); exp_q.push_back(pk(4,0,0,0,0,1,0,0,0,0,0,1,0,0));
        exp_q.push_back(pk(6,0,0,0,0,0,0,0,1,0,0,0,1,0));
        go("sw", 0, 6'b101011, 6'b000000, 0);
        add_fetch(0);
        go("fetch0", 0, 6'b000000, 6'b000000, 0);

        // MEM_LAT = 2 controller: lw takes 9 cycles
        rst[1] = 1'b0;
        add_fetch(2); exp_q.push_back(V_DEC); exp_q.push_back(pk(4,0,0,0,0,1,0,0,0,0,0,1,0,0));
        add_wait(pk(5,0,0,0,0,0,0,1,0,0,0,0,0,0), 3);
        exp_q.push_back(pk(9,0,0,0,0,0,1,0,0,2,0,0,1,0));
        go("lw_l2", 1, 6'b100011, 6'b000000, 0);
        add_fetch(2);
        go("fetch2", 1, 6'b000000, 6'b000000, 0);

        // MEM_LAT = 3 controller: reset during MEM_WR wait, then normal operation
        rst[2] = 1'b0;
        add_fetch(3); exp_q.push_back(V_DEC); exp_q.push_back(pk(4,0,0,0,0,1,0,0,0,0,0,1,0,0));
        add_wait(pk(6,0,0,0,0,0,0,0,1,0,0,0,0,0), 2);
        go("sw_part", 2, 6'b101011, 6'b000000, 0);
        rst[2] = 1'b1;
        #1; chk("rst_midwr", {10'd0, vec[2]}, 32'd0);
        @(negedge clk);
        #1; chk("rst_hold", {10'd0, vec[2]}, 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        add_fetch(3); exp_q.push_back(V_DEC); exp_q.push_back(pk(4,0,0,0,0,1,0,0,0,0,0,1,0,0));
        add_wait(pk(6,0,0,0,0,0,0,0,1,0,0,0,0,0), 3);
        exp_q.push_back(pk(6,0,0,0,0,0,0,0,1,0,0,0,1,0));
        go("sw_l3", 2, 6'b101011, 6'b000000, 0);
        add_fetch(3); exp_q.push_back(V_DEC); exp_q.push_back(pk(11,1,2,0,0,0,0,0,0,0,0,0,1,0));
        go("j_l3", 2, 6'b000010, 6'b000000, 0);
        add_fetch(3);
        go("fetch3", 2, 6'b000000, 6'b000000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MEM_LAT, default 0: extra wait cycles per memory access (instruction fetch, load, store); legal range 0..15.
REQ-002 Parameter ALUOP_W, default 3: ALUOp width, minimum 3; upper bits beyond bit 2 are tied 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op  input  6  opcode from IR; stable from the cycle after IRWrite.
REQ-006 funct  input  6  function field from IR; used when op=000000.
REQ-007 zero  input  1  ALU zero flag; sampled only in BRANCH.
REQ-008 PCWrite  output  1  PC load enable.
REQ-009 PCSrc  output  2  next PC: 00=PC+4, 01=branch target, 10=jump target, 11=rs (jr).
REQ-010 IRWrite  output  1  instruction register load enable.
REQ-011 RegDst  output  2  00=rt, 01=rd, 10=$31.
REQ-012 ALUSrc  output  1  0=rt, 1=extended immediate.
REQ-013 RegWrite, MemRead, MemWrite  output  1 each  register-file write, data/instruction memory read, memory write.
REQ-014 MemtoReg  output  2  00=ALU result, 01=lui immediate, 10=memory data, 11=PC+4.
REQ-015 ExtOp  output  1  1=zero-extend, 0=sign-extend.
REQ-016 ALUOp  output  ALUOP_W  000=funct-decoded, 001=add, 010=sub, 011=lui pass, 111=or.
REQ-017 done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-018 illegal  output  1  one-cycle pulse on an unsupported op/funct.
REQ-019 state  output  4  current state encoding, for debug.

Function
REQ-020 States and encodings: FETCH=0, DECODE=1, EXE_R=2, EXE_I=3, MEM_ADR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10, JUMP=11.
REQ-021 Outputs are Moore functions of state plus op/funct; an unlisted output is 0 in that state.
REQ-022 FETCH: MemRead=1; wait counter runs MEM_LAT cycles; on the last cycle only, IRWrite=1, PCWrite=1, PCSrc=00, then go to DECODE.
REQ-023 DECODE routing:
- R-type addu/subu (funct 100001/100011) -> EXE_R; jr (001000) -> JUMP.
- lw/sw -> MEM_ADR; beq -> BRANCH.
- ori/lui -> EXE_I; j (000010)/jal (000011) -> JUMP.
- anything else: illegal=1, done=1, -> FETCH.
REQ-024 EXE_R: ALUSrc=0, ALUOp=000 -> WB_R. WB_R: RegDst=01, MemtoReg=00, RegWrite=1, done=1 -> FETCH.
REQ-025 EXE_I: ori gives ALUSrc=1, ExtOp=1, ALUOp=111; lui gives ALUOp=011 -> WB_I. WB_I: RegDst=00, RegWrite=1, MemtoReg=00 (ori) or 01 (lui), done=1 -> FETCH.
REQ-026 MEM_ADR: ALUSrc=1, ExtOp=0, ALUOp=001 -> MEM_RD (lw) or MEM_WR (sw).
REQ-027 MEM_RD: MemRead=1 for MEM_LAT+1 cycles -> WB_MEM. MEM_WR: MemWrite=1 for MEM_LAT+1 cycles, done=1 on the last cycle -> FETCH.
REQ-028 WB_MEM: RegDst=00, MemtoReg=10, RegWrite=1, done=1 -> FETCH.
REQ-029 BRANCH: ALUSrc=0, ALUOp=010, PCSrc=01, PCWrite=zero, done=1 -> FETCH.
REQ-030 JUMP: PCWrite=1; PCSrc=11 for jr, else 10; jal also sets RegDst=10, MemtoReg=11, RegWrite=1; done=1 -> FETCH.
REQ-031 Wait counter is 4 bits, cleared on every state entry, never wraps; with MEM_LAT=0 every state lasts exactly 1 cycle.
REQ-032 Cycles per instruction = base + k*MEM_LAT, where k = number of memory states; base values: beq/j/jal/jr 3, R/ori/lui/sw 4, lw 5.
REQ-033 An unused state encoding (12..15) returns to FETCH on the next edge with all enables 0.

Reset
REQ-034 While reset=1: state=FETCH, counter=0, all outputs 0 (combinationally gated), including mid-instruction and mid-wait.
REQ-035 First rising edge after reset deasserts: controller is in FETCH with MemRead=1; first IRWrite occurs MEM_LAT cycles later.

Verification
REQ-036 MEM_LAT=0, op=000000 funct=100001 -> states 0,1,2,7; RegWrite=1, RegDst=01 in cycle 4; done in cycle 4 only.
REQ-037 MEM_LAT=2, lw (100011) -> FETCH 3 cycles, MEM_RD 3 cycles, 9 cycles total; RegWrite with MemtoReg=10 in the last cycle.
REQ-038 beq with zero=0 then zero=1 -> PCWrite=0 then 1 in BRANCH, PCSrc=01; 3 cycles each.
REQ-039 jal (000011) -> JUMP state: PCWrite=1, PCSrc=10, RegDst=10, MemtoReg=11, RegWrite=1.
REQ-040 op=111111 -> illegal=1 and done=1 in DECODE, then back to FETCH; no RegWrite or MemWrite at any point.
REQ-041 reset asserted mid-MEM_WR (MEM_LAT=3) -> MemWrite drops to 0 immediately and state=0; normal fetch resumes after release.
